seven_segment_scan_arbiter: RTL and testbench
=============================================

SEVEN_SEGMENT_SCAN_ARBITER -- requirements
Module: seven_segment_scan_arbiter

Interface
REQ-001 Parameter w_digit, 8: number of multiplexed digits.
REQ-002 Parameter scan_cycles, 50000: clk cycles each digit is lit (1 ms at 50 MHz); legal range is 2 or more.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-005 a_valid  in  1  requester A offers a frame.
REQ-006 a_ready  out  1  requester A frame accepted this cycle.
REQ-007 a_data  in  4*w_digit  A hex nibbles; nibble i drives digit i, with digit 0 rightmost.
REQ-008 a_dots  in  w_digit  A decimal-point mask; bit i is the dot of digit i.
REQ-009 b_valid, b_ready, b_data, b_dots  same as REQ-005..008, for requester B.
REQ-010 abcdefgh  out  8  active-high segments; bit7=a ... bit1=g, bit0=h (dot).
REQ-011 digit  out  w_digit  active-high one-hot digit enable.
REQ-012 frame_owner  out  1  0 = last accepted frame came from A, 1 = from B.
REQ-013 frame_done  out  1  one-cycle pulse, the cycle after any accepted frame.

Function
REQ-014 tick counter runs 0..scan_cycles-1; at scan_cycles-1 it wraps to 0 and digit index idx advances by 1, wrapping w_digit-1 -> 0.
REQ-015 Frame boundary = cycle with tick==scan_cycles-1 and idx==w_digit-1; transfers happen only there, so displayed frames never tear.
REQ-016 At a boundary: a single valid requester is granted; if both are valid, the requester not granted last time is granted (round-robin); if neither is valid, no grant.
REQ-017 ready is combinational: asserted only in the boundary cycle, only for the granted requester, and only while its valid is high; it is 0 in all other cycles.
REQ-018 Transfer = valid & ready; data and dots are latched into the frame register and displayed from idx 0 onward.
REQ-019 Requester holds valid and stable data until ready; the block never drops a held request and never samples data outside the boundary cycle.
REQ-020 No transfer: the frame register, frame_owner and round-robin state are unchanged.
REQ-021 digit and abcdefgh are registered together, one cycle after idx/frame change, so they never mismatch.
REQ-022 Hex decode (bits a..g,h=0): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, B=3E, C=9C, D=7A, E=9E, F=8E; bit0 = dots[idx].
REQ-023 frame_owner updates on transfer, in the same register stage as the frame.

Reset
REQ-024 rst_n low immediately clears: tick=0, idx=0, frame=0, dots=0, digit=0, abcdefgh=0, frame_owner=0, frame_done=0; round-robin favours A first.
REQ-025 a_ready and b_ready are 0 throughout reset.
REQ-026 First clock after release: digit=1, abcdefgh=FC.
REQ-027 Reset mid-frame loses the displayed frame; a requester still holding valid is served at the first boundary after release.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: a digit idx>0 whose nibble and all higher nibbles are zero shows segments 00 (dot bit still from dots); digit 0 is never blanked.
REQ-029 Macro absent: every digit is decoded per REQ-022; there is no blanking logic.

Verification (scan_cycles=4, w_digit=8)
REQ-030 Reset, no requests -> digit walks 01,02,04..80,01, 4 cycles each; abcdefgh=FC throughout.
REQ-031 A holds 0x12345678, dots 0x01 -> a_ready high exactly one cycle, at the boundary; frame_done next cycle; next frame shows digit0=FF, digit7=60.
REQ-032 A and B both valid continuously -> grants alternate A,B,A,B over successive boundaries; frame_owner toggles 0,1,0,1.
REQ-033 Data 0x00000A00 with macro defined -> digits 3..7=00, digit2=EE, digits 0,1=FC; without macro, digits 3..7=FC.
REQ-034 rst_n pulsed low mid-frame while A valid -> outputs clear asynchronously; a_ready stays 0 until the first boundary after release (cycle 32), then A is accepted.

Source files
------------

// File: rtl/seven_segment_scan_arbiter.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_arbiter
//
// Scans a frame of w_digit hex nibbles onto a multiplexed seven-segment
// display. Two requesters (A and B) compete for the frame register. The
// register is reloaded only at the frame boundary, which is the last tick of
// the last digit, so a displayed frame is never torn. When both requesters
// are valid, they are granted in round-robin order.
//
// Parameters
//   w_digit      number of multiplexed digits
//   scan_cycles  clk cycles each digit stays lit (>= 2)
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   a_valid/a_ready/a_data/a_dots   requester A frame handshake
//   b_valid/b_ready/b_data/b_dots   requester B frame handshake
//   abcdefgh     active-high segments, bit7=a .. bit1=g, bit0=dot
//   digit        active-high one-hot digit enable
//   frame_owner  0 = last accepted frame came from A, 1 = from B
//   frame_done   one-cycle pulse, the cycle after an accepted frame
//
// Build option
//   LEADING_ZERO_BLANK_EN  blank leading-zero digits (digit 0 is never blanked)
//
// Round-robin FSM
//   state     | meaning
//   rr_pref_a | A wins if A and B are both valid (reset state)
//   rr_pref_b | B wins if A and B are both valid
// ---------------------------------------------------------------------------
module seven_segment_scan_arbiter #(
   parameter int w_digit     = 8,
   parameter int scan_cycles = 50000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [4*w_digit-1:0] a_data,
   input  logic [w_digit-1:0]   a_dots,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [4*w_digit-1:0] b_data,
   input  logic [w_digit-1:0]   b_dots,
   output logic [7:0]           abcdefgh,
   output logic [w_digit-1:0]   digit,
   output logic                 frame_owner,
   output logic                 frame_done
);

   localparam int tick_w = $clog2(scan_cycles);
   localparam int idx_w  = (w_digit > 1) ? $clog2(w_digit) : 1;
   localparam logic [tick_w-1:0] tick_last = tick_w'(scan_cycles - 1);
   localparam logic [idx_w-1:0]  idx_last  = idx_w'(w_digit - 1);

   typedef enum logic {
      rr_pref_a = 1'b0,
      rr_pref_b = 1'b1
   } rr_state_t;

   rr_state_t            rr_state;
   rr_state_t            rr_next;
   logic [tick_w-1:0]    tick;
   logic [idx_w-1:0]     idx;
   logic [4*w_digit-1:0] frame_q;
   logic [w_digit-1:0]   dots_q;
   logic                 tick_wrap;
   logic                 boundary;
   logic                 xfer_a;
   logic                 xfer_b;
   logic [3:0]           cur_nib;
   logic [7:0]           cur_seg;

   assign tick_wrap = (tick == tick_last);
   assign boundary  = tick_wrap && (idx == idx_last);

   // Grant logic; tick is 0 during reset, so both readies stay low there.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      rr_next = rr_state;
      if (boundary) begin
         case (rr_state)
            rr_pref_a: begin
               if (a_valid) begin
                  a_ready = 1'b1;
                  rr_next = rr_pref_b;
               end else if (b_valid) begin
                  b_ready = 1'b1;
               end
            end
            rr_pref_b: begin
               if (b_valid) begin
                  b_ready = 1'b1;
                  rr_next = rr_pref_a;
               end else if (a_valid) begin
                  a_ready = 1'b1;
               end
            end
            default: rr_next = rr_pref_a;
         endcase
      end
   end

   assign xfer_a = a_valid && a_ready;
   assign xfer_b = b_valid && b_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_state <= rr_pref_a;
      end else begin
         rr_state <= rr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick        <= '0;
         idx         <= '0;
         frame_q     <= '0;
         dots_q      <= '0;
         frame_owner <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= xfer_a || xfer_b;
         if (tick_wrap) begin
            tick <= '0;
            idx  <= (idx == idx_last) ? '0 : idx + 1'b1;
         end else begin
            tick <= tick + 1'b1;
         end
         if (xfer_a) begin
            frame_q     <= a_data;
            dots_q      <= a_dots;
            frame_owner <= 1'b0;
         end else if (xfer_b) begin
            frame_q     <= b_data;
            dots_q      <= b_dots;
            frame_owner <= 1'b1;
         end
      end
   end

   assign cur_nib = 4'(frame_q >> {idx, 2'b00});

   always_comb begin
      cur_seg = 8'h00;
      case (cur_nib)
         4'h0: cur_seg = 8'hFC;
         4'h1: cur_seg = 8'h60;
         4'h2: cur_seg = 8'hDA;
         4'h3: cur_seg = 8'hF2;
         4'h4: cur_seg = 8'h66;
         4'h5: cur_seg = 8'hB6;
         4'h6: cur_seg = 8'hBE;
         4'h7: cur_seg = 8'hE0;
         4'h8: cur_seg = 8'hFE;
         4'h9: cur_seg = 8'hF6;
         4'hA: cur_seg = 8'hEE;
         4'hB: cur_seg = 8'h3E;
         4'hC: cur_seg = 8'h9C;
         4'hD: cur_seg = 8'h7A;
         4'hE: cur_seg = 8'h9E;
         4'hF: cur_seg = 8'h8E;
         default: cur_seg = 8'h00;
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      // This nibble and every nibble above it are zero: treat it as a leading zero.
      if ((idx != '0) && ((frame_q >> {idx, 2'b00}) == '0)) begin
         cur_seg = 8'h00;
      end
`endif
      cur_seg[0] = dots_q[idx];
   end

   // digit and segments are registered in the same stage so they always agree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit    <= '0;
         abcdefgh <= '0;
      end else begin
         digit    <= w_digit'(1) << idx;
         abcdefgh <= cur_seg;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_arbiter.sv
module tb_seven_segment_scan_arbiter;

   localparam int W = 8;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid = 1'b0;
   logic          a_ready;
   logic [31:0]   a_data = '0;
   logic [7:0]    a_dots = '0;
   logic          b_valid = 1'b0;
   logic          b_ready;
   logic [31:0]   b_data = '0;
   logic [7:0]    b_dots = '0;
   logic [7:0]    abcdefgh;
   logic [7:0]    digit;
   logic          frame_owner;
   logic          frame_done;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   int          c;
   logic [31:0] frame_m;
   logic [7:0]  dots_m;
   logic        owner_m;
   logic        pref_b_m;
   logic        done_m;
   logic [7:0]  disp_digit_m;
   logic [7:0]  disp_seg_m;
   logic        a_acc;
   logic        b_acc;

   logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   seven_segment_scan_arbiter #(.w_digit(W), .scan_cycles(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_dots(a_dots),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_dots(b_dots),
      .abcdefgh(abcdefgh), .digit(digit),
      .frame_owner(frame_owner), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [7:0] exp_seg(input logic [31:0] f, input logic [7:0] d, input int i);
      logic [3:0] nib;
      logic [7:0] s;
      nib = f[4*i +: 4];
      s = hex_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && (f >> (4*i)) == 32'd0) s = 8'h00;
`endif
      s[0] = d[i];
      return s;
   endfunction

   task automatic model_reset();
      c = 0; frame_m = '0; dots_m = '0; owner_m = 1'b0; pref_b_m = 1'b0;
      done_m = 1'b0; disp_digit_m = '0; disp_seg_m = '0; a_acc = 1'b0; b_acc = 1'b0;
   endtask

   // One interval per iteration; entered and left at posedge+1.
   // mode 0 idle, 1 A holds 0x12345678/dots 01, 2 both valid, 3 random, 4 A holds 0x00000A00
   task automatic run(input int ncyc, input int mode);
      logic bnd, ea, eb;
      int   idx;
      for (int k = 0; k < ncyc; k++) begin
         case (mode)
            0: begin a_valid = 1'b0; b_valid = 1'b0; end
            1: begin a_valid = 1'b1; a_data = 32'h12345678; a_dots = 8'h01; b_valid = 1'b0; end
            2: begin
               if (!a_valid || a_acc) begin a_data = $urandom; a_dots = 8'($urandom); end
               if (!b_valid || b_acc) begin b_data = $urandom; b_dots = 8'($urandom); end
               a_valid = 1'b1; b_valid = 1'b1;
            end
            3: begin
               if (!a_valid || a_acc) begin
                  a_valid = 1'($urandom); a_data = $urandom; a_dots = 8'($urandom);
               end
               if (!b_valid || b_acc) begin
                  b_valid = 1'($urandom); b_data = $urandom; b_dots = 8'($urandom);
               end
            end
            default: begin a_valid = 1'b1; a_data = 32'h00000A00; a_dots = 8'h00; b_valid = 1'b0; end
         endcase
         #1;
         idx = (c / S) % W;
         bnd = ((c % (S*W)) == S*W-1);
         ea  = bnd && a_valid && (!b_valid || !pref_b_m);
         eb  = bnd && b_valid && (!a_valid || pref_b_m);
         chk("a_ready", 32'(a_ready), 32'(ea));
         chk("b_ready", 32'(b_ready), 32'(eb));
         chk("digit", 32'(digit), 32'(disp_digit_m));
         chk("abcdefgh", 32'(abcdefgh), 32'(disp_seg_m));
         chk("frame_done", 32'(frame_done), 32'(done_m));
         chk("frame_owner", 32'(frame_owner), 32'(owner_m));
         @(posedge clk);
         disp_digit_m = 8'(1 << idx);
         disp_seg_m   = exp_seg(frame_m, dots_m, idx);
         done_m       = ea || eb;
         if (ea) begin frame_m = a_data; dots_m = a_dots; owner_m = 1'b0; pref_b_m = 1'b1; end
         if (eb) begin frame_m = b_data; dots_m = b_dots; owner_m = 1'b1; pref_b_m = 1'b0; end
         a_acc = ea;
         b_acc = eb;
         c++;
         #1;
      end
   endtask

   initial begin
      model_reset();
      // requests pending while in reset must not be acknowledged
      a_valid = 1'b1; b_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #2;
         chk("rst_a_ready", 32'(a_ready), 32'd0);
         chk("rst_b_ready", 32'(b_ready), 32'd0);
         chk("rst_digit", 32'(digit), 32'd0);
         chk("rst_abcdefgh", 32'(abcdefgh), 32'd0);
         chk("rst_owner", 32'(frame_owner), 32'd0);
         chk("rst_done", 32'(frame_done), 32'd0);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      run(40, 0);    // idle scan
      run(80, 1);    // single requester A
      run(140, 2);   // both valid: alternate
      run(70, 4);    // leading-zero frame
      run(600, 3);   // random traffic

      // asynchronous reset in the middle of a frame while A keeps requesting
      run(13, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_digit", 32'(digit), 32'd0);
      chk("arst_abcdefgh", 32'(abcdefgh), 32'd0);
      chk("arst_owner", 32'(frame_owner), 32'd0);
      chk("arst_done", 32'(frame_done), 32'd0);
      chk("arst_a_ready", 32'(a_ready), 32'd0);
      model_reset();
      repeat (2) begin
         @(posedge clk); #2;
         chk("arst_hold_a_ready", 32'(a_ready), 32'd0);
         chk("arst_hold_digit", 32'(digit), 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run(45, 1);
      run(100, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
